// File: rtl/vector_sweep_checker.sv
// vector_sweep_checker
//   Walks every input combination 0 .. 2^N_IN-1 onto STIM, waits SETTLE
//   cycles for the circuit under test and its golden model to respond, then
//   compares RESP against EXP. Mismatches are counted, and the first failing
//   vector is recorded. Each vector takes SETTLE+1 cycles (SETTLE in WAIT,
//   one in CHECK).
//
//   Build option: define VSC_HALT_ON_ERR_EN to end the sweep at the first
//   mismatch. STIM and FIRST_ERR_VEC then both hold the failing vector.
//
// Ports
//   CLK            system clock, rising edge
//   RST            asynchronous, active-high reset
//   START          begin a sweep (only sampled in IDLE)
//   RESP [N_OUT]   circuit-under-test response to STIM
//   EXP  [N_OUT]   golden-model response to STIM
//   STIM [N_IN]    current input vector
//   BUSY           high from the accepted START through the DONE cycle
//   DONE           one-cycle pulse at sweep end
//   ERR_FLAG       sticky mismatch flag for the current/last sweep
//   ERR_CNT[N_IN+1] number of mismatching vectors (cannot overflow)
//   FIRST_ERR_VEC  STIM value of the first mismatch
module vector_sweep_checker #(
  parameter int N_IN   = 9,
  parameter int N_OUT  = 2,
  parameter int SETTLE = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [N_OUT-1:0]  RESP,
  input  logic [N_OUT-1:0]  EXP,
  output logic [N_IN-1:0]   STIM,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR_FLAG,
  output logic [N_IN:0]     ERR_CNT,
  output logic [N_IN-1:0]   FIRST_ERR_VEC
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  // The counter is loaded with SETTLE and leaves WAIT when it reads 1.
  // As a result, the value 0 is never needed while the sweep is running.
  localparam int            CW        = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE);
  localparam logic [N_IN-1:0] LAST_VEC = '1;

`ifdef VSC_HALT_ON_ERR_EN
  localparam bit HALT_ON_ERR = 1'b1;
`else
  localparam bit HALT_ON_ERR = 1'b0;
`endif

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          mismatch;

  // An X/Z bit makes the compare X. In that case the if() below treats the
  // vector as matching, so only a definite difference counts as an error.
  assign mismatch = (RESP != EXP);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= S_IDLE;
      cnt           <= '0;
      STIM          <= '0;
      BUSY          <= 1'b0;
      DONE          <= 1'b0;
      ERR_FLAG      <= 1'b0;
      ERR_CNT       <= '0;
      FIRST_ERR_VEC <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            state         <= S_WAIT;
            STIM          <= '0;
            cnt           <= SETTLE_LD;
            BUSY          <= 1'b1;
            ERR_FLAG      <= 1'b0;
            ERR_CNT       <= '0;
            FIRST_ERR_VEC <= '0;
          end
        end

        S_WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= S_CHECK;
        end

        S_CHECK: begin
          if (mismatch) begin
            ERR_CNT  <= ERR_CNT + 1'b1;
            ERR_FLAG <= 1'b1;
            if (!ERR_FLAG) FIRST_ERR_VEC <= STIM;
          end
          // The last vector, or a halting mismatch, ends the sweep.
          // STIM keeps its value so it shows where the sweep stopped.
          if (STIM == LAST_VEC || (HALT_ON_ERR && mismatch)) begin
            state <= S_FINISH;
            DONE  <= 1'b1;
          end else begin
            STIM  <= STIM + 1'b1;
            cnt   <= SETTLE_LD;
            state <= S_WAIT;
          end
        end

        S_FINISH: begin
          state <= S_IDLE;
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/vector_sweep_checker.md
Name: vector_sweep_checker

Overview:
- Sequential, parametrised successor to the team's fixed-vector circuit benches.
- Drives every one of the 2^N_IN input combinations to a combinational circuit under test, one after another.
- Waits a programmable settle time for each vector, then compares the circuit response against a golden model.
- Counts mismatches and records the first failing vector; sits between the stimulus side and the circuit/golden-model pair in the test harness.

Parameters:
N_IN, 9, input vector width (number of circuit inputs A..I); 1..16
N_OUT, 2, response width (number of circuit outputs X, Y); 1..32
SETTLE, 1, cycles waited after STIM changes before sampling; >=1

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous, active-high reset
START  input  1  begin sweep; sampled only in IDLE
RESP  input  N_OUT  response of circuit under test to STIM
EXP  input  N_OUT  golden-model response to STIM
STIM  output  N_IN  current input vector to circuit and golden model
BUSY  output  1  high while a sweep is in progress
DONE  output  1  one-cycle pulse at sweep end
ERR_FLAG  output  1  sticky: at least one mismatch this sweep
ERR_CNT  output  N_IN+1  number of mismatching vectors this sweep
FIRST_ERR_VEC  output  N_IN  STIM value of first mismatch

Behaviour:
- Interface: single clock CLK; RST asynchronous, active-high. All outputs registered.
- Reset values: state IDLE; STIM=0, BUSY=0, DONE=0, ERR_FLAG=0, ERR_CNT=0, FIRST_ERR_VEC=0; settle counter=0.
- States: IDLE, WAIT, CHECK, FINISH.
- IDLE:
  - START=1 at an edge -> WAIT; STIM<=0, settle counter<=SETTLE, BUSY<=1.
  - Clears ERR_CNT, ERR_FLAG and FIRST_ERR_VEC on the same edge.
- WAIT:
  - Counter decrements once per cycle.
  - When counter==1 at an edge -> CHECK. WAIT therefore lasts exactly SETTLE cycles.
- CHECK: one cycle; RESP and EXP are compared at the closing edge.
  - Mismatch (any bit differs): ERR_CNT<=ERR_CNT+1; ERR_FLAG<=1.
  - If ERR_FLAG was 0 at that edge: FIRST_ERR_VEC<=STIM.
  - STIM != all-ones -> STIM<=STIM+1, counter<=SETTLE, -> WAIT.
  - STIM == all-ones -> FINISH. STIM holds the all-ones value; no wrap.
- FINISH:
  - DONE=1 and BUSY=1 for exactly one cycle.
  - Next edge -> IDLE with BUSY<=0, DONE<=0.
- Latency: each vector occupies SETTLE+1 cycles. DONE is high in the cycle beginning 2^N_IN*(SETTLE+1) edges after the edge that sampled START.
- Width rule: ERR_CNT is N_IN+1 bits, so the maximum of 2^N_IN mismatches never overflows; no saturation logic is needed.
- START outside IDLE (WAIT/CHECK/FINISH) is ignored; there is no queuing.
- Results (ERR_CNT, ERR_FLAG, FIRST_ERR_VEC, final STIM) hold in IDLE until the next accepted START.
- RST mid-sweep: all registers return to reset values immediately (asynchronous). No DONE pulse is produced.
- RESP/EXP containing X/Z: treated as mismatch only if the comparison evaluates true; the bench must not drive X.

Optional Feature:
- Macro: VSC_HALT_ON_ERR_EN.
- Defined:
  - The first mismatch in CHECK goes directly to FINISH; STIM holds the failing vector.
  - ERR_CNT ends at 1; DONE pulses normally.
  - Latency shortens to (k+1)*(SETTLE+1) edges, where k is the failing vector index.
- Not defined: the sweep always covers all 2^N_IN vectors, as above.

Test Plan:
- Defaults; EXP=RESP=function of STIM (identity match); pulse START -> BUSY high next cycle, DONE pulse 1024 cycles after START edge, ERR_CNT=0, ERR_FLAG=0, FIRST_ERR_VEC=0, STIM=9'h1FF.
- Defaults; RESP[0] inverted only when STIM==9'h025 and STIM==9'h0F0 -> ERR_CNT=2, ERR_FLAG=1, FIRST_ERR_VEC=9'h025.
- N_IN=3, SETTLE=3, RESP always differs from EXP -> DONE 32 cycles after START, ERR_CNT=8, FIRST_ERR_VEC=0.
- Defaults; assert RST for 1 cycle when STIM==9'h080 -> all outputs 0 immediately, state IDLE, no DONE; new START runs a full 1024-cycle sweep.
- START re-pulsed while BUSY (STIM==9'h010) -> ignored; sweep continues uninterrupted, DONE at cycle 1024.
- VSC_HALT_ON_ERR_EN defined, defaults, mismatch only at STIM==9'h025 (k=37) -> DONE 76 cycles after START, ERR_CNT=1, STIM=FIRST_ERR_VEC=9'h025.
